// File: rtl/pipe_host_pkg.sv
// Shared definitions for the pipeline host command sequencer: opcodes,
// controller state encoding, readback source select and address widths.
package pipe_host_pkg;

    localparam int IMEM_AW = 9;
    localparam int DMEM_AW = 8;
    localparam int REG_AW  = 4;

    localparam logic [2:0] OP_WR_IMEM = 3'd0;
    localparam logic [2:0] OP_WR_DMEM = 3'd1;
    localparam logic [2:0] OP_RD_IMEM = 3'd2;
    localparam logic [2:0] OP_RD_DMEM = 3'd3;
    localparam logic [2:0] OP_RD_REG  = 3'd4;
    localparam logic [2:0] OP_RUN     = 3'd5;
    localparam logic [2:0] OP_STOP    = 3'd6;
    localparam logic [2:0] OP_RSVD    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_WAIT,
        S_RUN,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        SRC_IMEM,
        SRC_DMEM,
        SRC_REG
    } rd_src_t;

    // A command is legal when its opcode is defined and its address fits
    // the target space; the command address is always imem-sized, so the
    // narrower spaces must see their unused upper bits at zero.
    function automatic logic cmd_legal(input logic [2:0] op,
                                       input logic [IMEM_AW-1:0] addr);
        logic ok;
        ok = 1'b1;
        case (op)
            OP_WR_DMEM, OP_RD_DMEM: ok = (addr[IMEM_AW-1:DMEM_AW] == '0);
            OP_RD_REG:              ok = (addr[IMEM_AW-1:REG_AW] == '0);
            OP_RSVD:                ok = 1'b0;
            default:                ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pipe_host_ctrl_if.sv
// Command/response channel between the host and the pipeline sequencer.
// master = host side issuing commands, slave = sequencer.
interface pipe_host_ctrl_if;
    import pipe_host_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [IMEM_AW-1:0] cmd_addr;
    logic [31:0]        cmd_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_data;
    logic               rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/host_run_counter.sv
// Run-cycle counter for the RUN command: load clears the count and latches
// the limit, enable advances it with saturation at all-ones. expire flags
// the cycle whose edge completes the last of `limit` cycles (limit 0 = free-run).
module host_run_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] limit_in,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_inc,
    output logic             expire
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] limit_reg;

    // Count and limit registers; load has priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            limit_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
            limit_reg <= limit_in;
        end else if (enable) begin
            count_reg <= count_inc;
        end
    end

    // Saturating successor and terminal-count compare.
    always_comb begin
        count_inc = (&count_reg) ? count_reg : count_reg + CNT_W'(1);
        expire    = (limit_reg != '0) && (count_reg == limit_reg - CNT_W'(1));
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_host_ctrl.sv
// Host-side command sequencer for the 5-stage pipeline core. Takes one
// command at a time, drives the core's program/debug port with registered
// strobes, gates pipe_en for RUN, and returns exactly one response each.
module pipe_host_ctrl
    import pipe_host_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_host_ctrl_if.slave    bus,
    output logic               pipe_en,
    output logic               imem_we,
    output logic               imem_re,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_data,
    output logic               dmem_we,
    output logic               dmem_re,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_data,
    output logic               reg_re,
    output logic [REG_AW-1:0]  reg_addr,
    input  logic [31:0]        imem_out,
    input  logic [31:0]        dmem_out,
    input  logic [31:0]        reg_out,
    output logic               running,
    output logic [CNT_W-1:0]   run_cycles
);

    state_t state_reg, state_next;
    rd_src_t rd_src_reg, rd_src_next;

    logic               cmd_ready_reg, cmd_ready_next;
    logic               rsp_valid_reg, rsp_valid_next;
    logic [31:0]        rsp_data_reg, rsp_data_next;
    logic               rsp_err_reg, rsp_err_next;
    logic               pipe_en_reg, pipe_en_next;
    logic               imem_we_reg, imem_we_next;
    logic               imem_re_reg, imem_re_next;
    logic [IMEM_AW-1:0] imem_addr_reg, imem_addr_next;
    logic [31:0]        imem_data_reg, imem_data_next;
    logic               dmem_we_reg, dmem_we_next;
    logic               dmem_re_reg, dmem_re_next;
    logic [DMEM_AW-1:0] dmem_addr_reg, dmem_addr_next;
    logic [31:0]        dmem_data_reg, dmem_data_next;
    logic               reg_re_reg, reg_re_next;
    logic [REG_AW-1:0]  reg_addr_reg, reg_addr_next;
    logic [2:0]         rd_cnt_reg, rd_cnt_next;
    logic               err_sticky_reg, err_sticky_next;

    logic               accept;
    logic               run_load;
    logic               run_err;
    logic [CNT_W-1:0]   run_count;
    logic [CNT_W-1:0]   run_count_inc;
    logic               run_expire;
    logic [31:0]        rd_data;

    assign accept = bus.cmd_valid && cmd_ready_reg;

    host_run_counter #(
        .CNT_W (CNT_W)
    ) u_run_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (run_load),
        .limit_in  (CNT_W'(bus.cmd_data)),
        .enable    (state_reg == S_RUN),
        .count     (run_count),
        .count_inc (run_count_inc),
        .expire    (run_expire)
    );

    // Readback source for the read currently in flight.
    always_comb begin
        rd_data = reg_out;
        case (rd_src_reg)
            SRC_IMEM: rd_data = imem_out;
            SRC_DMEM: rd_data = dmem_out;
            default:  rd_data = reg_out;
        endcase
    end

    // Next-state and next-output decode; every core-facing output is
    // computed here and registered below, so cmd_* never reaches the core
    // combinationally.
    always_comb begin
        state_next      = state_reg;
        rd_src_next     = rd_src_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_err_next    = rsp_err_reg;
        pipe_en_next    = pipe_en_reg;
        imem_we_next    = 1'b0;
        dmem_we_next    = 1'b0;
        imem_re_next    = imem_re_reg;
        dmem_re_next    = dmem_re_reg;
        reg_re_next     = reg_re_reg;
        imem_addr_next  = imem_addr_reg;
        imem_data_next  = imem_data_reg;
        dmem_addr_next  = dmem_addr_reg;
        dmem_data_next  = dmem_data_reg;
        reg_addr_next   = reg_addr_reg;
        rd_cnt_next     = rd_cnt_reg;
        err_sticky_next = err_sticky_reg;
        run_load        = 1'b0;
        run_err         = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (!cmd_legal(bus.cmd_op, bus.cmd_addr)) begin
                        // Rejected commands never touch the core.
                        state_next     = S_RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_data_next  = 32'd0;
                    end else begin
                        case (bus.cmd_op)
                            OP_WR_IMEM: begin
                                imem_we_next   = 1'b1;
                                imem_addr_next = bus.cmd_addr;
                                imem_data_next = bus.cmd_data;
                                state_next     = S_WRITE;
                            end
                            OP_WR_DMEM: begin
                                dmem_we_next   = 1'b1;
                                dmem_addr_next = bus.cmd_addr[DMEM_AW-1:0];
                                dmem_data_next = bus.cmd_data;
                                state_next     = S_WRITE;
                            end
                            OP_RD_IMEM: begin
                                imem_re_next   = 1'b1;
                                imem_addr_next = bus.cmd_addr;
                                rd_src_next    = SRC_IMEM;
                                rd_cnt_next    = 3'(RD_LAT - 1);
                                state_next     = S_RD_WAIT;
                            end
                            OP_RD_DMEM: begin
                                dmem_re_next   = 1'b1;
                                dmem_addr_next = bus.cmd_addr[DMEM_AW-1:0];
                                rd_src_next    = SRC_DMEM;
                                rd_cnt_next    = 3'(RD_LAT - 1);
                                state_next     = S_RD_WAIT;
                            end
                            OP_RD_REG: begin
                                reg_re_next    = 1'b1;
                                reg_addr_next  = bus.cmd_addr[REG_AW-1:0];
                                rd_src_next    = SRC_REG;
                                rd_cnt_next    = 3'(RD_LAT - 1);
                                state_next     = S_RD_WAIT;
                            end
                            OP_RUN: begin
                                run_load        = 1'b1;
                                pipe_en_next    = 1'b1;
                                err_sticky_next = 1'b0;
                                state_next      = S_RUN;
                            end
                            default: begin
                                // STOP with nothing running is a harmless no-op.
                                state_next     = S_RESP;
                                rsp_valid_next = 1'b1;
                                rsp_err_next   = 1'b0;
                                rsp_data_next  = 32'd0;
                            end
                        endcase
                    end
                end
            end

            S_WRITE: begin
                state_next     = S_RESP;
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b0;
                rsp_data_next  = 32'd0;
            end

            S_RD_WAIT: begin
                if (rd_cnt_reg == 3'd0) begin
                    rsp_data_next  = rd_data;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    imem_re_next   = 1'b0;
                    dmem_re_next   = 1'b0;
                    reg_re_next    = 1'b0;
                    state_next     = S_RESP;
                end else begin
                    rd_cnt_next = rd_cnt_reg - 3'd1;
                end
            end

            S_RUN: begin
                // Count expiry takes precedence; a STOP landing on the same
                // edge is simply consumed. Any other op seen on the final
                // edge still flags the response as erroneous.
                if (run_expire || (accept && bus.cmd_op == OP_STOP)) begin
                    run_err        = err_sticky_reg || (accept && bus.cmd_op != OP_STOP);
                    pipe_en_next   = 1'b0;
                    state_next     = S_RESP;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = run_err;
                    // Errored responses always carry zero data.
                    rsp_data_next  = run_err ? 32'd0 : 32'(run_count_inc);
                end else if (accept) begin
                    err_sticky_next = 1'b1;
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        cmd_ready_next = (state_next == S_IDLE) || (state_next == S_RUN);
    end

    // State and registered outputs; reset drops everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            rd_src_reg     <= SRC_IMEM;
            cmd_ready_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_data_reg   <= 32'd0;
            rsp_err_reg    <= 1'b0;
            pipe_en_reg    <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_re_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_data_reg  <= 32'd0;
            dmem_we_reg    <= 1'b0;
            dmem_re_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_data_reg  <= 32'd0;
            reg_re_reg     <= 1'b0;
            reg_addr_reg   <= '0;
            rd_cnt_reg     <= 3'd0;
            err_sticky_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rd_src_reg     <= rd_src_next;
            cmd_ready_reg  <= cmd_ready_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_err_reg    <= rsp_err_next;
            pipe_en_reg    <= pipe_en_next;
            imem_we_reg    <= imem_we_next;
            imem_re_reg    <= imem_re_next;
            imem_addr_reg  <= imem_addr_next;
            imem_data_reg  <= imem_data_next;
            dmem_we_reg    <= dmem_we_next;
            dmem_re_reg    <= dmem_re_next;
            dmem_addr_reg  <= dmem_addr_next;
            dmem_data_reg  <= dmem_data_next;
            reg_re_reg     <= reg_re_next;
            reg_addr_reg   <= reg_addr_next;
            rd_cnt_reg     <= rd_cnt_next;
            err_sticky_reg <= err_sticky_next;
        end
    end

    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;

    assign pipe_en    = pipe_en_reg;
    assign imem_we    = imem_we_reg;
    assign imem_re    = imem_re_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_data  = imem_data_reg;
    assign dmem_we    = dmem_we_reg;
    assign dmem_re    = dmem_re_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_data  = dmem_data_reg;
    assign reg_re     = reg_re_reg;
    assign reg_addr   = reg_addr_reg;
    assign running    = (state_reg == S_RUN);
    assign run_cycles = run_count;

endmodule

// File: tb/tb_pipe_host_ctrl.sv
// Directed bench for pipe_host_ctrl with a small behavioural core model
// (combinational readback, write on clock edge) and edge-counting monitors.
module tb_pipe_host_ctrl;
    import pipe_host_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_host_ctrl_if bus();

    logic               pipe_en, imem_we, imem_re, dmem_we, dmem_re, reg_re, running;
    logic [IMEM_AW-1:0] imem_addr;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [REG_AW-1:0]  reg_addr;
    logic [31:0]        imem_data, dmem_data, imem_out, dmem_out, reg_out;
    logic [31:0]        run_cycles;

    pipe_host_ctrl #(.RD_LAT(1), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .pipe_en    (pipe_en),
        .imem_we    (imem_we),
        .imem_re    (imem_re),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_we    (dmem_we),
        .dmem_re    (dmem_re),
        .dmem_addr  (dmem_addr),
        .dmem_data  (dmem_data),
        .reg_re     (reg_re),
        .reg_addr   (reg_addr),
        .imem_out   (imem_out),
        .dmem_out   (dmem_out),
        .reg_out    (reg_out),
        .running    (running),
        .run_cycles (run_cycles)
    );

    // Core model
    logic [31:0] imem_m [512];
    logic [31:0] dmem_m [256];
    logic [31:0] reg_m  [16];
    always @(posedge clk) begin
        if (imem_we) imem_m[imem_addr] <= imem_data;
        if (dmem_we) dmem_m[dmem_addr] <= dmem_data;
    end
    assign imem_out = imem_m[imem_addr];
    assign dmem_out = dmem_m[dmem_addr];
    assign reg_out  = reg_m[reg_addr];

    // Per-edge monitors
    int pe_cnt = 0, imem_we_cnt = 0, imem_re_cnt = 0, dmem_we_cnt = 0;
    int dmem_re_cnt = 0, reg_re_cnt = 0, viol_cnt = 0, run_mis_cnt = 0;
    always @(posedge clk) begin
        if (pipe_en) pe_cnt <= pe_cnt + 1;
        if (imem_we) imem_we_cnt <= imem_we_cnt + 1;
        if (imem_re) imem_re_cnt <= imem_re_cnt + 1;
        if (dmem_we) dmem_we_cnt <= dmem_we_cnt + 1;
        if (dmem_re) dmem_re_cnt <= dmem_re_cnt + 1;
        if (reg_re)  reg_re_cnt  <= reg_re_cnt + 1;
        if (pipe_en && (imem_we || imem_re || dmem_we || dmem_re || reg_re))
            viol_cnt <= viol_cnt + 1;
        if (running !== pipe_en) run_mis_cnt <= run_mis_cnt + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present a command and hold it until the edge that accepts it;
    // returns 1 time unit after that edge.
    task automatic send(input logic [2:0] op, input logic [8:0] addr, input logic [31:0] data);
        bit done;
        done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.cmd_ready === 1'b1) done = 1'b1;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $error("FAIL send_timeout: observed cmd_ready low for 50 cycles, expected acceptance");
        end
    endtask

    // Count edges from the current point until rsp_valid is seen.
    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.rsp_valid !== 1'b1) begin
            vectors++;
            miscompares++;
            $error("FAIL rsp_timeout: observed no rsp_valid in 200 cycles, expected a response");
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b, b2;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_addr  = 9'd0;
        bus.cmd_data  = 32'd0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) reg_m[i] = 32'(i) * 32'h1111_1111;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("reset_pipe_en",    32'(pipe_en), 32'd0);
        chk("reset_cmd_ready",  32'(bus.cmd_ready), 32'd0);
        chk("reset_rsp_valid",  32'(bus.rsp_valid), 32'd0);
        chk("reset_running",    32'(running), 32'd0);
        chk("reset_run_cycles", run_cycles, 32'd0);
        chk("reset_imem_we",    32'(imem_we), 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // WR_IMEM then RD_IMEM
        b = imem_we_cnt;
        send(OP_WR_IMEM, 9'h005, 32'hE081_2003);
        wait_rsp(n);
        chk("wr_imem_latency", n, 1);
        chk("wr_imem_err",  32'(bus.rsp_err), 32'd0);
        chk("wr_imem_data", bus.rsp_data, 32'd0);
        consume();
        chk("wr_imem_we_cycles", imem_we_cnt - b, 1);
        chk("wr_imem_stored", imem_m[5], 32'hE081_2003);

        send(OP_RD_IMEM, 9'h005, 32'd0);
        wait_rsp(n);
        chk("rd_imem_latency", n, 1);
        chk("rd_imem_data", bus.rsp_data, 32'hE081_2003);
        chk("rd_imem_err",  32'(bus.rsp_err), 32'd0);
        // Back-pressure: response must hold while rsp_ready is low
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rsp_data",  bus.rsp_data, 32'hE081_2003);
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        consume();
        chk("post_consume_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_consume_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Illegal addresses
        b = dmem_we_cnt;
        send(OP_WR_DMEM, 9'h100, 32'h1234_5678);
        wait_rsp(n);
        chk("wr_dmem_bad_latency", n, 0);
        chk("wr_dmem_bad_err",  32'(bus.rsp_err), 32'd1);
        chk("wr_dmem_bad_data", bus.rsp_data, 32'd0);
        consume();
        chk("wr_dmem_bad_no_we", dmem_we_cnt - b, 0);

        b = reg_re_cnt;
        send(OP_RD_REG, 9'h013, 32'd0);
        wait_rsp(n);
        chk("rd_reg_bad_err",  32'(bus.rsp_err), 32'd1);
        chk("rd_reg_bad_data", bus.rsp_data, 32'd0);
        consume();
        chk("rd_reg_bad_no_re", reg_re_cnt - b, 0);

        // Legal dmem write/read, register read
        send(OP_WR_DMEM, 9'h022, 32'hCAFE_F00D);
        wait_rsp(n);
        chk("wr_dmem_err", 32'(bus.rsp_err), 32'd0);
        consume();
        b = dmem_re_cnt;
        send(OP_RD_DMEM, 9'h022, 32'd0);
        wait_rsp(n);
        chk("rd_dmem_latency", n, 1);
        chk("rd_dmem_data", bus.rsp_data, 32'hCAFE_F00D);
        consume();
        chk("rd_dmem_re_cycles", dmem_re_cnt - b, 1);

        send(OP_RD_REG, 9'h003, 32'd0);
        wait_rsp(n);
        chk("rd_reg_data", bus.rsp_data, 32'h3333_3333);
        chk("rd_reg_err",  32'(bus.rsp_err), 32'd0);
        consume();

        // Reserved op and STOP while idle
        send(OP_RSVD, 9'h000, 32'hFFFF_FFFF);
        wait_rsp(n);
        chk("rsvd_err",  32'(bus.rsp_err), 32'd1);
        chk("rsvd_data", bus.rsp_data, 32'd0);
        consume();
        send(OP_STOP, 9'h000, 32'd0);
        wait_rsp(n);
        chk("stop_idle_err",  32'(bus.rsp_err), 32'd0);
        chk("stop_idle_data", bus.rsp_data, 32'd0);
        consume();

        // RUN N=10
        b = pe_cnt;
        send(OP_RUN, 9'h000, 32'd10);
        wait_rsp(n);
        chk("run10_latency", n, 10);
        chk("run10_data", bus.rsp_data, 32'd10);
        chk("run10_err",  32'(bus.rsp_err), 32'd0);
        chk("run10_pipe_en_low", 32'(pipe_en), 32'd0);
        chk("run10_running_low", 32'(running), 32'd0);
        chk("run10_run_cycles", run_cycles, 32'd10);
        chk("run10_pe_cycles", pe_cnt - b, 10);
        consume();

        // Free-run, STOP accepted on the 37th enabled cycle
        b = pe_cnt;
        send(OP_RUN, 9'h000, 32'd0);
        chk("run0_running", 32'(running), 32'd1);
        repeat (36) @(posedge clk);
        #1;
        send(OP_STOP, 9'h000, 32'd0);
        chk("stop_pipe_en_low", 32'(pipe_en), 32'd0);
        chk("stop_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("stop_data", bus.rsp_data, 32'd37);
        chk("stop_err",  32'(bus.rsp_err), 32'd0);
        chk("stop_pe_cycles", pe_cnt - b, 37);
        consume();

        // Foreign op during free-run: discarded, run continues, sticky error
        b2 = imem_re_cnt;
        send(OP_RUN, 9'h000, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        send(OP_RD_IMEM, 9'h005, 32'd0);
        chk("midrun_running", 32'(running), 32'd1);
        chk("midrun_pipe_en", 32'(pipe_en), 32'd1);
        chk("midrun_no_rsp",  32'(bus.rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        send(OP_STOP, 9'h000, 32'd0);
        wait_rsp(n);
        chk("midrun_err",  32'(bus.rsp_err), 32'd1);
        chk("midrun_data", bus.rsp_data, 32'd0);
        chk("midrun_no_re", imem_re_cnt - b2, 0);
        consume();

        // STOP on the same edge the count expires
        b = pe_cnt;
        send(OP_RUN, 9'h000, 32'd4);
        repeat (3) @(posedge clk);
        #1;
        send(OP_STOP, 9'h000, 32'd0);
        chk("tie_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("tie_data", bus.rsp_data, 32'd4);
        chk("tie_err",  32'(bus.rsp_err), 32'd0);
        chk("tie_pe_cycles", pe_cnt - b, 4);
        consume();
        repeat (2) @(posedge clk);
        #1;
        chk("tie_no_extra_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("tie_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Asynchronous reset in the middle of RUN N=100
        send(OP_RUN, 9'h000, 32'd100);
        repeat (19) @(posedge clk);
        #1;
        chk("prereset_running", 32'(running), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("areset_pipe_en",    32'(pipe_en), 32'd0);
        chk("areset_rsp_valid",  32'(bus.rsp_valid), 32'd0);
        chk("areset_running",    32'(running), 32'd0);
        chk("areset_run_cycles", run_cycles, 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        send(OP_WR_IMEM, 9'h1FF, 32'hA5A5_0001);
        wait_rsp(n);
        chk("after_reset_latency", n, 1);
        chk("after_reset_err", 32'(bus.rsp_err), 32'd0);
        consume();
        chk("after_reset_stored", imem_m[511], 32'hA5A5_0001);

        // Global invariants
        chk("strobe_vs_pipe_en", viol_cnt, 0);
        chk("running_vs_pipe_en", run_mis_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_host_ctrl.md
Name: pipe_host_ctrl

Overview:
- Host-side command sequencer sitting directly upstream of the 5-stage pipeline core.
- Drives the pipeline's program/debug port: imem load/readback, dmem load/readback, register readback and pipe_en gating.
- Accepts one command at a time over a valid/ready channel and returns exactly one response per command.
- Runs the core for a bounded cycle count or free-runs until STOP.

Parameters:
- RD_LAT, 1: cycles from read strobe/address assertion to data valid on imem_out/dmem_out/reg_out (legal range 1..7).
- CNT_W, 32: width of run-cycle counter and RUN count field.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_op  in  3  0 WR_IMEM, 1 WR_DMEM, 2 RD_IMEM, 3 RD_DMEM, 4 RD_REG, 5 RUN, 6 STOP, 7 reserved
- cmd_addr  in  9  imem addr / dmem addr[7:0] / reg addr[3:0]
- cmd_data  in  32  write data; RUN cycle count (low CNT_W bits)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_data  out  32  read data, or RUN cycles executed, else 0
- rsp_err  out  1  command rejected/illegal
- pipe_en  out  1  pipeline run enable
- imem_we, imem_re  out  1 each
- imem_addr  out  9
- imem_data  out  32
- dmem_we, dmem_re  out  1 each (to dmem_we_external/dmem_re_external)
- dmem_addr  out  8
- dmem_data  out  32
- reg_re  out  1
- reg_addr  out  4
- imem_out, dmem_out, reg_out  in  32 each  readback data from core
- running  out  1  high while in RUN state
- run_cycles  out  CNT_W  live cycle count of current/last run

Behaviour:
- Reset (async): all outputs 0, state IDLE, run_cycles 0. Reset mid-run drops pipe_en immediately and discards any pending response.
- States: IDLE, WRITE, RD_WAIT, RUN, RESP.
- IDLE: cmd_ready=1. On accept, decode:
  - WR_IMEM: one-cycle WRITE with imem_we=1, imem_addr=cmd_addr, imem_data=cmd_data; then RESP with data 0.
  - WR_DMEM: one-cycle WRITE with dmem_we=1; cmd_addr[8]=1 gives err, no write.
  - RD_*: assert the matching *_re and address, hold for RD_LAT cycles (RD_WAIT counter), capture data on the RD_LAT-th edge, then RESP.
  - RD_DMEM with addr[8]=1, or RD_REG with addr[8:4]!=0: err, no strobe.
  - RUN: clear run_cycles, enter RUN.
  - STOP in IDLE: RESP with data 0, err 0.
  - op 7: RESP with err=1.
- Error responses go straight to RESP without touching the core. rsp_data=0 on any error.
- WRITE/RD_WAIT/RESP: cmd_ready=0. pipe_en is guaranteed 0 whenever any we/re strobe is high.
- RUN: pipe_en=1 and run_cycles increments each cycle.
  - Count N>0: pipe_en high exactly N cycles, then RESP with rsp_data=N.
  - N=0: free-run; run_cycles saturates at all-ones.
  - cmd_ready=1 during RUN. STOP accepted: pipe_en low from the next cycle, RESP with rsp_data=cycles executed including the accept cycle. Other ops: accepted and discarded, sticky err flag set, run continues, final RUN response carries rsp_err=1. STOP accepted in the same cycle the count expires: count expiry wins, STOP is consumed.
- RESP: rsp_valid=1, data/err held stable until rsp_ready; return to IDLE the following cycle. cmd_ready=0 in RESP, so there is no command/response overlap.
- Latency: write accept to rsp_valid = 2 cycles. Read accept to rsp_valid = RD_LAT+1 cycles.
- rsp_data/rsp_err are registered; all core-facing strobes are registered, no combinational path from cmd_* to core outputs.

Decomposition:
- Shared package pipe_host_pkg: opcode constants OP_WR_IMEM..OP_STOP, state encoding, IMEM_AW=9, DMEM_AW=8, REG_AW=4.
- One sub-module: host_run_counter (load/clear, enable, saturating CNT_W counter with terminal-count compare) used for RUN; the RD_WAIT counter is inline.

Test Plan:
- WR_IMEM addr 0x005 data 0xE0812003, then RD_IMEM 0x005 (RD_LAT=1): imem_we pulses 1 cycle, then rsp_data=0xE0812003, rsp_err=0, rsp_valid 2 cycles after read accept.
- WR_DMEM addr 0x100: rsp_err=1, dmem_we never asserted. RD_REG addr 0x013: rsp_err=1, reg_re never asserted.
- RUN N=10: pipe_en high exactly 10 consecutive cycles, rsp_data=10, running falls with pipe_en.
- RUN N=0, STOP after 37 cycles: pipe_en drops next cycle, rsp_data=37. RD_IMEM issued mid-run: run continues, final rsp_err=1.
- Hold rsp_ready=0 for 5 cycles after a read: rsp_valid/rsp_data stable, cmd_ready=0 throughout; completes on rsp_ready.
- Assert reset during RUN N=100 at cycle 20: pipe_en, rsp_valid and running go 0 asynchronously, next command accepted normally.
